// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB encodings for the two-master arbiter: HTRANS, HRESP, HSIZE and
// HBURST constants, the arbiter FSM state encoding, the ownership encoding
// used by the address/data muxes, and the per-master request bundle.
// No ports (package).
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    // Everything one master drives toward the slave side.
    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [31:0] hwdata;
    } ahb_mst_t;

endpackage

// File: rtl/ahb_arb_mux.sv
// ahb_arb_mux
// Combinational slave-side muxing. Address/control follow the address-phase
// owner, write data follows the data-phase owner; with no owner the bus is
// parked at zero with HTRANS=IDLE.
// Ports:
//   addr_owner, data_owner : current address/data phase owners
//   m0, m1                 : master request bundles
//   haddr..hburst          : muxed address/control to the slave
//   hwdata                 : muxed write data to the slave
module ahb_arb_mux
    import ahb_pkg::*;
(
    input  owner_e      addr_owner,
    input  owner_e      data_owner,
    input  ahb_mst_t    m0,
    input  ahb_mst_t    m1,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata
);

    always_comb begin
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = '0;
        hburst = '0;
        case (addr_owner)
            OWN_M0: begin
                haddr  = m0.haddr;
                htrans = m0.htrans;
                hwrite = m0.hwrite;
                hsize  = m0.hsize;
                hburst = m0.hburst;
            end
            OWN_M1: begin
                haddr  = m1.haddr;
                htrans = m1.htrans;
                hwrite = m1.hwrite;
                hsize  = m1.hsize;
                hburst = m1.hburst;
            end
            default: ;
        endcase

        hwdata = '0;
        case (data_owner)
            OWN_M0:  hwdata = m0.hwdata;
            OWN_M1:  hwdata = m1.hwdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
// Two-master AHB arbiter with pipelined address/data ownership and a beat
// limit that forces handover to a waiting rival after MAX_BEATS accepted
// transfers (only at a non-SEQ/non-BUSY boundary).
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking
// (simultaneous requests go to the master not served last); otherwise M0
// always wins ties.
// Ports:
//   iHCLK, iHRESETn               : clock, async active-low reset
//   iHBUSREQ_Mx / oHGRANT_Mx      : request / registered grant per master
//   iH{ADDR,TRANS,WRITE,SIZE,BURST,WDATA}_Mx : master-side bus signals
//   oH{ADDR,TRANS,WRITE,SIZE,BURST,WDATA}    : muxed slave-side bus
//   iHREADY, iHRDATA, iHRESP      : slave response
//   oHREADY, oHRDATA, oHRESP      : response passed to both masters
//   oHMASTER                      : address-phase owner (0=M0, 1=M1)
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int MAX_BEATS = 16
) (
    input  logic        iHCLK,
    input  logic        iHRESETn,
    input  logic        iHBUSREQ_M0,
    input  logic        iHBUSREQ_M1,
    output logic        oHGRANT_M0,
    output logic        oHGRANT_M1,
    input  logic [31:0] iHADDR_M0,
    input  logic [1:0]  iHTRANS_M0,
    input  logic        iHWRITE_M0,
    input  logic [2:0]  iHSIZE_M0,
    input  logic [2:0]  iHBURST_M0,
    input  logic [31:0] iHWDATA_M0,
    input  logic [31:0] iHADDR_M1,
    input  logic [1:0]  iHTRANS_M1,
    input  logic        iHWRITE_M1,
    input  logic [2:0]  iHSIZE_M1,
    input  logic [2:0]  iHBURST_M1,
    input  logic [31:0] iHWDATA_M1,
    output logic [31:0] oHADDR,
    output logic [1:0]  oHTRANS,
    output logic        oHWRITE,
    output logic [2:0]  oHSIZE,
    output logic [2:0]  oHBURST,
    output logic [31:0] oHWDATA,
    input  logic        iHREADY,
    input  logic [31:0] iHRDATA,
    input  logic [1:0]  iHRESP,
    output logic        oHREADY,
    output logic [31:0] oHRDATA,
    output logic [1:0]  oHRESP,
    output logic        oHMASTER
);

    localparam int              CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

    arb_state_e       state_q, state_d;
    owner_e           addr_owner_q, addr_owner_d;
    owner_e           data_owner_q, data_owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic             last_served_q, last_served_d;   // 0=M0, 1=M1
`endif

    logic       owner_req, rival_req, accept, at_boundary, beats_hit, tie_to_m1;
    logic [1:0] owner_trans;
    arb_state_e rival_state;
    ahb_mst_t   m0_bus, m1_bus;

    always_comb begin
        owner_trans = (state_q == ARB_M1) ? iHTRANS_M1 : iHTRANS_M0;
        owner_req   = (state_q == ARB_M1) ? iHBUSREQ_M1 : iHBUSREQ_M0;
        rival_req   = (state_q == ARB_M1) ? iHBUSREQ_M0 : iHBUSREQ_M1;
        rival_state = (state_q == ARB_M1) ? ARB_M0 : ARB_M1;
        accept      = (state_q != ARB_IDLE) && iHREADY && owner_trans[1];
        // Handover is only legal between bursts, never mid SEQ/BUSY.
        at_boundary = (owner_trans != HTRANS_SEQ) && (owner_trans != HTRANS_BUSY);
        // The limit counts the transfer accepted on this very edge, so the
        // grant moves on the edge that accepts the MAX_BEATS-th transfer.
        beats_hit   = (beat_cnt_q == CNT_MAX) ||
                      (accept && (beat_cnt_q == CNT_MAX - CNT_W'(1)));
`ifdef ARB_ROUND_ROBIN_EN
        tie_to_m1   = ~last_served_q;
`else
        tie_to_m1   = 1'b0;
`endif

        state_d = state_q;
        if (iHREADY) begin
            case (state_q)
                ARB_IDLE: begin
                    if (iHBUSREQ_M0 && iHBUSREQ_M1) state_d = tie_to_m1 ? ARB_M1 : ARB_M0;
                    else if (iHBUSREQ_M0)           state_d = ARB_M0;
                    else if (iHBUSREQ_M1)           state_d = ARB_M1;
                end
                ARB_M0, ARB_M1: begin
                    if (at_boundary && (!owner_req || (beats_hit && rival_req)))
                        state_d = rival_req ? rival_state : ARB_IDLE;
                end
                default: state_d = ARB_IDLE;
            endcase
        end

        beat_cnt_d = beat_cnt_q;
        if (state_d != state_q)                  beat_cnt_d = '0;
        else if (accept && beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + CNT_W'(1);

`ifdef ARB_ROUND_ROBIN_EN
        last_served_d = last_served_q;
        if (state_d != state_q && state_d == ARB_M0) last_served_d = 1'b0;
        if (state_d != state_q && state_d == ARB_M1) last_served_d = 1'b1;
`endif

        // The granted master owns the next address phase; the address owner
        // moves on to the data phase. Both stall with the bus.
        addr_owner_d = addr_owner_q;
        data_owner_d = data_owner_q;
        if (iHREADY) begin
            case (state_q)
                ARB_M0:  addr_owner_d = OWN_M0;
                ARB_M1:  addr_owner_d = OWN_M1;
                default: addr_owner_d = OWN_NONE;
            endcase
            data_owner_d = addr_owner_q;
        end
    end

    always_ff @(posedge iHCLK or negedge iHRESETn) begin
        if (!iHRESETn) begin
            state_q       <= ARB_IDLE;
            addr_owner_q  <= OWN_NONE;
            data_owner_q  <= OWN_NONE;
            beat_cnt_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_served_q <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            addr_owner_q  <= addr_owner_d;
            data_owner_q  <= data_owner_d;
            beat_cnt_q    <= beat_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_served_q <= last_served_d;
`endif
        end
    end

    assign oHGRANT_M0 = (state_q == ARB_M0);
    assign oHGRANT_M1 = (state_q == ARB_M1);
    assign oHMASTER   = (addr_owner_q == OWN_M1);

    assign m0_bus = '{haddr: iHADDR_M0, htrans: iHTRANS_M0, hwrite: iHWRITE_M0,
                      hsize: iHSIZE_M0, hburst: iHBURST_M0, hwdata: iHWDATA_M0};
    assign m1_bus = '{haddr: iHADDR_M1, htrans: iHTRANS_M1, hwrite: iHWRITE_M1,
                      hsize: iHSIZE_M1, hburst: iHBURST_M1, hwdata: iHWDATA_M1};

    ahb_arb_mux u_mux (
        .addr_owner (addr_owner_q),
        .data_owner (data_owner_q),
        .m0         (m0_bus),
        .m1         (m1_bus),
        .haddr      (oHADDR),
        .htrans     (oHTRANS),
        .hwrite     (oHWRITE),
        .hsize      (oHSIZE),
        .hburst     (oHBURST),
        .hwdata     (oHWDATA)
    );

    // Responses are not arbitrated; both masters see the slave directly.
    assign oHREADY = iHREADY;
    assign oHRDATA = iHRDATA;
    assign oHRESP  = iHRESP;

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 16, giving the transfers a master may complete before a pending rival is granted.
REQ-002 SHALL have port iHCLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iHRESETn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports iHBUSREQ_M0 and iHBUSREQ_M1, input, 1 each, bus requests.
REQ-005 SHALL have ports oHGRANT_M0 and oHGRANT_M1, output, 1 each, registered grants.
REQ-006 SHALL have, for x=0 and x=1, the inputs iHADDR_Mx [32], iHTRANS_Mx [2], iHWRITE_Mx [1], iHSIZE_Mx [3], iHBURST_Mx [3] and iHWDATA_Mx [32].
REQ-007 SHALL have slave-side outputs oHADDR [32], oHTRANS [2], oHWRITE [1], oHSIZE [3], oHBURST [3] and oHWDATA [32].
REQ-008 SHALL have slave-side inputs iHREADY [1], iHRDATA [32] and iHRESP [2].
REQ-009 SHALL have outputs oHREADY [1], oHRDATA [32] and oHRESP [2], passed through to both masters unchanged.
REQ-010 SHALL have output oHMASTER, 1, giving the current address-phase owner (0=M0, 1=M1).

Function
REQ-011 SHALL implement the FSM states ARB_IDLE, ARB_M0 and ARB_M1, evaluating transitions only on edges where iHREADY=1 and holding state otherwise.
REQ-012 SHALL leave ARB_IDLE for the state of a requesting master; if both request, the tie follows REQ-022.
REQ-013 SHALL leave ARB_Mx when the owner deasserts its request and the owner's iHTRANS is not SEQ or BUSY:
- go to the rival's state if the rival requests;
- otherwise go to ARB_IDLE.
REQ-014 SHALL count owner transfers accepted (iHREADY=1, iHTRANS[1]=1) in a saturating beat counter cleared on every state change.
REQ-015 SHALL hand over to a requesting rival when the counter reaches MAX_BEATS and the owner's iHTRANS is not SEQ or BUSY, even if the owner still requests.
REQ-016 SHALL drive oHGRANT_Mx high exactly while the state is ARB_Mx (Moore output, one cycle after the deciding edge).
REQ-017 SHALL track ownership in two registers, both updated only when iHREADY=1:
- addr_owner, loaded with the granted master, or with none in ARB_IDLE;
- data_owner, loaded with addr_owner.
REQ-018 SHALL mux oHADDR, oHTRANS, oHWRITE, oHSIZE and oHBURST from addr_owner; with no owner they SHALL be 0, IDLE (2'b00), 0, 0 and 0.
REQ-019 SHALL mux oHWDATA from data_owner, and drive 0 when there is no data owner.
REQ-020 SHALL pass ERROR, RETRY and SPLIT responses to both masters without altering arbitration.

Reset
REQ-021 SHALL, while iHRESETn=0, immediately force:
- state ARB_IDLE, grants 0, both owners none, beat counter 0;
- oHTRANS IDLE, oHMASTER 0;
- last_served = M1.
A reset mid-burst SHALL abandon the burst with no further outputs.

Configuration
REQ-022 SHALL use macro ARB_ROUND_ROBIN_EN to select tie-breaking:
- defined: simultaneous requests grant the master other than last_served, and last_served updates on each grant;
- undefined: M0 always wins ties.
REQ-015 applies in both builds.

Structure
REQ-023 SHALL place the HTRANS, HRESP, HSIZE and HBURST constants and the FSM state encoding in shared package ahb_pkg.
REQ-024 SHALL implement the REQ-018/REQ-019 combinational muxing as sub-module ahb_arb_mux.

Verification
REQ-025 SHALL cover single request:
- M0 requests from idle with iHREADY=1 -> oHGRANT_M0=1 next cycle;
- M0's address on oHADDR the cycle after that;
- oHMASTER=0.
REQ-026 SHALL cover simultaneous requests from reset:
- with the macro: M0 first, then M1 after M0 releases;
- without it: M0 wins on every retry.
REQ-027 SHALL cover MAX_BEATS=4 with M0 doing back-to-back NONSEQ and M1 requesting -> grant moves to M1 after M0's 4th accepted transfer.
REQ-028 SHALL cover iHREADY=0 for 3 cycles during handover -> grant, owners and outputs frozen; oHWDATA still follows the previous owner.
REQ-029 SHALL cover an INCR4 burst with M0's request dropped after beat 1 -> no handover until the burst ends (non-SEQ boundary).
REQ-030 SHALL cover iHRESETn pulsed low mid-burst -> oHTRANS=IDLE and grants 0 in the same cycle.
